// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher with an in-order {word, pc} queue feeding decode.
// A redirect flushes the queue and marks every in-flight memory response as stale.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   words [DEPTH];
    logic [31:0]   pcs   [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, inflight, discard;
    logic [31:0]   fetch_pc, resp_pc, target_pc;
    logic [CW:0]   credits;
    logic          accept, push, pop, drop;

    assign target_pc      = redirect_pc & 32'hFFFF_FFFC;
    assign credits        = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = reset_n && !redirect && (credits < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign drop           = imem_resp_valid && (discard != '0);
    assign push           = imem_resp_valid && (discard == '0) && !redirect;
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready && !redirect;
    assign instr          = words[head];
    assign instr_pc       = pcs[head];
    assign instr_pcplus4  = pcs[head] + 32'd4;

    // resp_pc tracks the address of the next non-stale response, so no address FIFO is needed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else begin
            fetch_pc <= redirect ? target_pc : accept ? fetch_pc + 32'd4 : fetch_pc;
            resp_pc  <= redirect ? target_pc : push ? resp_pc + 32'd4 : resp_pc;
            head     <= redirect ? '0 : head + AW'(pop);
            tail     <= redirect ? '0 : tail + AW'(push);
            count    <= redirect ? '0 : count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(imem_resp_valid);
            discard  <= redirect ? inflight - CW'(imem_resp_valid) : discard - CW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            words[tail] <= imem_resp_data;
            pcs[tail]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed fetch_queue bench with a latency-programmable memory model
// and a scoreboard of expected {pc, word} entries checked as decode pops them.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] pc; logic [31:0] data; int rcyc; } sb_t;
    typedef struct { int due; logic [31:0] data; bit stale; } mr_t;

    logic        clk = 0, reset_n = 0, redirect = 0;
    logic        imem_req_ready = 1, imem_resp_valid = 0, instr_ready = 1;
    logic [31:0] redirect_pc = 0, imem_resp_data = 0;
    logic        imem_req_valid, instr_valid;
    logic [31:0] imem_req_addr, instr, instr_pc, instr_pcplus4;

    sb_t         sb[$];
    mr_t         mq[$];
    int          cyc = 0, lat = 1, last_due = 0, compared = 0, mismatched = 0;
    int          accepts = 0, pops = 0, a0, p0;
    logic [31:0] exp_fpc = RESET_PC, stall_addr = 0;
    bit          stalled = 0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        int nstale = 0;
        int due;
        bit resp = 0;
        bit done = 0;
        bit exp_v;
        if (mq.size() != 0 && mq[0].due == cyc) begin
            resp = 1;
            if (!mq[0].stale)
                foreach (sb[i])
                    if (!done && sb[i].rcyc < 0) begin
                        sb[i].rcyc = cyc + 1;
                        done = 1;
                    end
        end
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mq[0].data : $urandom;
        #1;
        foreach (mq[i]) nstale += int'(mq[i].stale);
        exp_v = reset_n && !redirect && (sb.size() + nstale < DEPTH);
        chk("req_valid", imem_req_valid, exp_v);
        chk("instr_valid", instr_valid, sb.size() != 0 && sb[0].rcyc >= 0 && sb[0].rcyc <= cyc);
        if (stalled && !redirect && reset_n) begin
            chk("addr_hold", imem_req_addr, stall_addr);
            chk("valid_hold", imem_req_valid, 1);
        end
        stalled    = imem_req_valid && !imem_req_ready;
        stall_addr = imem_req_addr;
        if (instr_valid && instr_ready && !redirect && sb.size() != 0) begin
            chk("instr_pc", instr_pc, sb[0].pc);
            chk("instr", instr, sb[0].data);
            chk("instr_pcplus4", instr_pcplus4, sb[0].pc + 32'd4);
            void'(sb.pop_front());
            pops++;
        end
        if (redirect) begin
            sb.delete();
            foreach (mq[i]) mq[i].stale = 1;
            exp_fpc = {redirect_pc[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_fpc);
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            mq.push_back('{due, word_at(imem_req_addr), 1'b0});
            sb.push_back('{exp_fpc, word_at(exp_fpc), -1});
            exp_fpc += 32'd4;
            accepts++;
        end
        if (resp) void'(mq.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        sb.delete();
        mq.delete();
        exp_fpc  = RESET_PC;
        stalled  = 0;
        last_due = cyc;
        repeat (2) step();
        reset_n = 1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1;
        redirect_pc = pc;
        step();
        redirect = 0;
    endtask

    initial begin
        // reset release, 1-cycle memory, decoder always ready
        do_reset();
        chk("first_addr", imem_req_addr, RESET_PC);
        repeat (4) step();
        p0 = pops;
        repeat (10) step();
        chk("throughput", pops - p0, 10);

        // decoder stalled: queue fills to DEPTH, then drains in order
        do_reset();
        instr_ready = 0;
        a0 = accepts;
        repeat (10) step();
        chk("fill_accepts", accepts - a0, DEPTH);
        chk("fill_req_valid", imem_req_valid, 0);
        instr_ready = 1;
        repeat (10) step();

        // 3-cycle memory, redirect with 3 requests in flight
        lat = 3;
        do_redirect(32'h0000_0040);
        repeat (3) step();
        do_redirect(32'h0000_0100);
        repeat (15) step();

        // redirect coinciding with a response and a pop; low PC bits ignored
        lat = 1;
        repeat (6) step();
        do_redirect(32'h0000_0303);
        repeat (8) step();

        // memory and decoder back-pressure
        lat = 2;
        for (int i = 0; i < 60; i++) begin
            imem_req_ready = ($urandom_range(0, 1) == 1);
            instr_ready    = ($urandom_range(0, 3) != 0);
            step();
        end
        imem_req_ready = 1;
        instr_ready    = 1;
        repeat (8) step();

        // address wrap past 0xFFFF_FFFC
        lat = 1;
        do_redirect(32'hFFFF_FFF0);
        repeat (12) step();

        // reset in the middle of traffic
        lat = 3;
        repeat (3) step();
        do_reset();
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between instruction memory and the decode stage. Issues sequential word fetches from a fetch PC, holds returned instruction words with their PCs in a small in-order FIFO, and presents one instruction per cycle to decode. Decode, including the immediate extender, consumes `instr` from this block. A control-flow redirect flushes the queue and discards any memory responses still in flight.

## Interface
Parameters:
- `DEPTH`, 4: queue entries, power of two, ≥2. Also bounds requests in flight.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, 32: new fetch address; sampled when `redirect`=1.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_req_addr`, out, 32: fetch address; word aligned.
- `imem_resp_valid`, in, 1: response word valid. Responses return in request order, at least 1 cycle after acceptance.
- `imem_resp_data`, in, 32: instruction word.
- `instr_valid`, out, 1: head entry valid.
- `instr_ready`, in, 1: decode consumes the head.
- `instr`, out, 32: head instruction word.
- `instr_pc`, out, 32: PC of the head instruction.
- `instr_pcplus4`, out, 32: `instr_pc` + 4, mod 2^32.

## Operation
- State:
  - `fetch_pc`.
  - Queue: `DEPTH` entries of {word, pc}, with `head`, `tail` and `count` (0..DEPTH).
  - `inflight` (0..DEPTH): requests accepted but not yet answered.
  - `discard` (0..DEPTH, ≤ `inflight`): in-flight requests that are stale.
- Request issue:
  - `imem_req_valid` = !`redirect` && (`count` + `inflight` < DEPTH).
  - `imem_req_addr` = `fetch_pc`.
  - On acceptance (`valid` && `ready`): `fetch_pc` += 4 (wraps mod 2^32) and `inflight` += 1.
- Response handling:
  - If `discard` > 0: drop the word and decrement `discard`.
  - Otherwise: write {data, pc} at `tail`. The pc comes from a parallel FIFO of issued addresses, or is derived from the PC of the last pushed entry.
  - Every response decrements `inflight`.
- Output:
  - `instr_valid` = (`count` ≠ 0).
  - `instr`, `instr_pc` and `instr_pcplus4` come from the head entry.
  - A pop occurs when `instr_valid` && `instr_ready`.
  - Output fields are don't-care when `instr_valid`=0.
- Redirect, which has priority over everything:
  - `count`, `head` and `tail` go to 0. A pop in the same cycle is ignored.
  - `fetch_pc` ← `redirect_pc`.
  - No request is issued that cycle.
  - `discard` ← (`inflight` + `discard`-adjusted) such that every request accepted before the redirect edge is dropped. A response arriving in the redirect cycle is itself dropped: `discard` ← `inflight` − `imem_resp_valid`.
  - `inflight` updates normally.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - Overflow cannot occur, because credits count in-flight requests.
- Pointers wrap modulo `DEPTH`.
- `redirect_pc[1:0]` is ignored (forced to 0).

## Timing
- Reset values, asserted asynchronously:
  - `fetch_pc`=RESET_PC; `count`=`inflight`=`discard`=0.
  - `instr_valid`=0.
  - `imem_req_valid`=0 while `reset_n`=0. It is 1 in the first cycle after deassertion, with `imem_req_addr`=RESET_PC.
- Reset asserted mid-operation clears all state immediately. Responses for pre-reset requests are the memory's responsibility (memory is reset with the same `reset_n`).
- Fetch-to-decode latency:
  - Request accepted in cycle t, response in cycle t+k: `instr_valid` appears in cycle t+k+1. There is no bypass from response to output.
- Redirect latency:
  - `redirect` in cycle t: first request with `redirect_pc` in cycle t+1.
  - With 1-cycle memory, the first redirected instruction is valid in cycle t+3.
- Steady-state throughput with an always-ready memory and decoder: one instruction per cycle, provided the memory's response latency ≤ DEPTH−1.
- `imem_req_addr` stays stable while `imem_req_valid`=1 and `imem_req_ready`=0. The only exception is a redirect, which withdraws the request.

## Test plan
- Reset release, 1-cycle memory, decoder always ready -> requests 0x0, 0x4, 0x8, … on consecutive cycles. `instr_valid` first rises 2 cycles after the first request, with `instr_pc`=0x0 and `instr_pcplus4`=0x4. Thereafter one instruction per cycle in order.
- `instr_ready`=0 held -> exactly 4 requests issue (DEPTH=4). `count` reaches 4 and `imem_req_valid` stays 0. Releasing ready drains 0x0..0xC, then fetching resumes at 0x10.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x100 -> all 3 stale responses are dropped, nothing stale reaches decode, and the first `instr_pc` is 0x100.
- Redirect in the same cycle as a response and a pop -> the queue is empty next cycle, the response is dropped, and the next request address is `redirect_pc`.
- `imem_req_ready` toggling 0/1 -> `imem_req_addr` holds while stalled. No address is skipped or duplicated.
- `fetch_pc`=0xFFFF_FFFC -> the next request is 0x0000_0000, and `instr_pcplus4`=0x0 for the entry at 0xFFFF_FFFC.
